// File: rtl/regfile_wb_pkg.sv
// Shared types for the regfile write-back path.
// The request types are sized for the default 32 x 32-bit register file.
package regfile_wb_pkg;

    localparam int unsigned PkgNReg = 32;
    localparam int unsigned PkgXLen = 32;
    localparam int unsigned RegZero = 0;

    typedef logic [$clog2(PkgNReg)-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t           addr;
        logic [PkgXLen-1:0]  data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant searched upward from ptr,
// plus the pointer value to load after an accept.
module rr_arbiter #(
    parameter int unsigned NReq = 2,
    localparam int unsigned PtrW = (NReq > 1) ? $clog2(NReq) : 1
) (
    input  logic [NReq-1:0] req,
    input  logic [PtrW-1:0] ptr,
    output logic [NReq-1:0] gnt,
    output logic [PtrW-1:0] gnt_id,
    output logic            any,
    output logic [PtrW-1:0] ptr_next
);

    int unsigned idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < NReq; i++) begin
            idx = (int'(ptr) + i) % NReq;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = PtrW'(idx);
            end
        end
    end

    // Pointer moves just past the winner so it becomes lowest priority.
    always_comb begin
        ptr_next = ptr;
        if (any) begin
            ptr_next = (gnt_id == PtrW'(NReq - 1)) ? '0 : gnt_id + PtrW'(1);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter feeding a single registered regfile write port.
// Optional statistics counters are enabled with REGFILE_WB_STATS_EN.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int unsigned XLen = 32,
    parameter int unsigned NReg = 32,
    parameter int unsigned NReq = 2,
    localparam int unsigned AW  = $clog2(NReg),
    localparam int unsigned IdW = (NReq > 1) ? $clog2(NReq) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NReq-1:0]      req_valid_i,
    output logic [NReq-1:0]      req_ready_o,
    input  logic [NReq*AW-1:0]   req_addr_i,
    input  logic [NReq*XLen-1:0] req_data_i,
    output logic [AW-1:0]        a3_o,
    output logic                 we3_o,
    output logic [XLen-1:0]      wd3_o,
    output logic [NReg-1:0]      pend_o,
`ifdef REGFILE_WB_STATS_EN
    output logic [NReq*32-1:0]   stat_grant_o,
    output logic [31:0]          stat_conflict_o,
`endif
    output logic [IdW-1:0]       grant_id_o
);

    wb_req_t         req_arr [NReq];
    wb_req_t         sel_req;
    logic [NReq-1:0] gnt;
    logic [IdW-1:0]  gnt_id;
    logic            gnt_any;
    logic            accept;
    logic            wr_live;
    logic [IdW-1:0]  ptr_reg;
    logic [IdW-1:0]  ptr_next;

    logic            we3_reg;
    logic [AW-1:0]   a3_reg;
    logic [XLen-1:0] wd3_reg;
    logic [NReg-1:0] pend_reg;
    logic [IdW-1:0]  gid_reg;

    generate
        for (genvar gi = 0; gi < NReq; gi++) begin : g_unpack
            assign req_arr[gi].addr = req_addr_i[gi*AW +: AW];
            assign req_arr[gi].data = req_data_i[gi*XLen +: XLen];
        end
    endgenerate

    rr_arbiter #(.NReq(NReq)) u_rr (
        .req      (req_valid_i),
        .ptr      (ptr_reg),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .any      (gnt_any),
        .ptr_next (ptr_next)
    );

    assign req_ready_o = rst_i ? '0 : gnt;
    assign accept      = gnt_any && !rst_i;
    assign sel_req     = req_arr[gnt_id];
    // x0 writes are consumed like any other request but never reach the port.
    assign wr_live     = accept && (sel_req.addr != reg_addr_t'(RegZero));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_reg  <= '0;
            we3_reg  <= 1'b0;
            a3_reg   <= '0;
            wd3_reg  <= '0;
            pend_reg <= '0;
            gid_reg  <= '0;
        end else begin
            we3_reg  <= wr_live;
            pend_reg <= wr_live ? (NReg'(1) << sel_req.addr) : '0;
            if (accept) begin
                ptr_reg <= ptr_next;
                a3_reg  <= sel_req.addr;
                wd3_reg <= sel_req.data;
                gid_reg <= gnt_id;
            end
        end
    end

    // Reset also kills a write already sitting in the output stage.
    assign we3_o      = we3_reg && !rst_i;
    assign pend_o     = rst_i ? '0 : pend_reg;
    assign a3_o       = a3_reg;
    assign wd3_o      = wd3_reg;
    assign grant_id_o = gid_reg;

`ifdef REGFILE_WB_STATS_EN
    logic [31:0] conflict_reg;

    generate
        for (genvar gi = 0; gi < NReq; gi++) begin : g_stat
            logic [31:0] cnt_reg;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_reg <= '0;
                end else if (req_ready_o[gi] && req_valid_i[gi] && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
            assign stat_grant_o[gi*32 +: 32] = cnt_reg;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            conflict_reg <= '0;
        end else if (accept && ($countones(req_valid_i) > 1) && (conflict_reg != '1)) begin
            conflict_reg <= conflict_reg + 32'd1;
        end
    end

    assign stat_conflict_o = conflict_reg;
`endif

endmodule
